// File: rtl/mem_ack_arbiter_if.sv
// Shared ack-bus handshake between the requesters (master) and the arbiter (slave).
// Requesters raise in_req and in_id. The arbiter answers with ownership and owner-ID broadcasts.
`timescale 1ns/1ps
interface mem_ack_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   in_req;
   logic [2*N_REQ-1:0] in_id;
   logic [N_REQ-1:0]   out_owned;
   logic               out_ack_valid;
   logic [1:0]         out_ack_id;
   logic               out_busy;
   logic               out_timeout;

   modport master (
      output in_req,
      output in_id,
      input  out_owned,
      input  out_ack_valid,
      input  out_ack_id,
      input  out_busy,
      input  out_timeout
   );

   modport slave (
      input  in_req,
      input  in_id,
      output out_owned,
      output out_ack_valid,
      output out_ack_id,
      output out_busy,
      output out_timeout
   );
endinterface

// File: rtl/mem_ack_arbiter.sv
// Round-robin owner of the shared ack bus. A grant appears 1 cycle after the request is sampled, and every output is registered.
// There is no backpressure. The owner keeps the bus until it drops its request or the hold limit forces a release.
`timescale 1ns/1ps
module mem_ack_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 64,
   parameter int HOLD_W   = 7
) (
   input logic              clk,
   input logic              rst_n,
   mem_ack_arbiter_if.slave bus
);
   localparam int                PTR_W      = (N_REQ > 2) ? 2 : 1;
   localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
   localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [N_REQ-1:0]   owned_q;
   logic               ack_valid_q;
   logic [1:0]         ack_id_q;
   logic               busy_q;
   logic               timeout_q;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W:0]     cand;
   logic               owner_req;
   logic [PTR_W-1:0]   next_ptr;

   // The search walks downward so the last hit is the one closest to rr_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (cand > {1'b0, LAST_IDX}) begin
            cand = cand - (PTR_W+1)'(N_REQ);
         end
         if (bus.in_req[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign owner_req = bus.in_req[owner];
   assign next_ptr  = (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         hold_cnt    <= '0;
         owned_q     <= '0;
         ack_valid_q <= 1'b0;
         ack_id_q    <= 2'b00;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         ack_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= GRANT;
                  owner       <= win_idx;
                  owned_q     <= N_REQ'(1) << win_idx;
                  ack_id_q    <= bus.in_id[{win_idx, 1'b0} +: 2];
                  ack_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  hold_cnt    <= '0;
               end
            end
            GRANT: begin
               // A dropped request wins over an expiring hold, so no timeout pulse is raised.
               if (!owner_req) begin
                  state   <= RELEASE;
                  owned_q <= '0;
               end else if (TIMEOUT_EN && hold_cnt == HOLD_LAST) begin
                  state     <= RELEASE;
                  owned_q   <= '0;
                  timeout_q <= 1'b1;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            RELEASE: begin
               state    <= IDLE;
               busy_q   <= 1'b0;
               rr_ptr   <= next_ptr;
               hold_cnt <= '0;
            end
            default: begin
               state   <= IDLE;
               owned_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_owned     = owned_q;
   assign bus.out_ack_valid = ack_valid_q;
   assign bus.out_ack_id    = ack_id_q;
   assign bus.out_busy      = busy_q;
   assign bus.out_timeout   = timeout_q;

   a_owned_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(owned_q));
   a_valid_busy:   assert property (@(posedge clk) disable iff (!rst_n) ack_valid_q |-> busy_q);
endmodule

// File: doc/mem_ack_arbiter.md
Name: mem_ack_arbiter

Overview:
- Owns the shared 3-bit ack bus that mem_command_port drives through its request/id outputs and its owned input.
- Arbitrates among N requesters with round-robin priority: the memory command port plus the crypto cores.
- Grants exclusive ownership to one requester and broadcasts the owner's source ID for one cycle.
- Revokes ownership when the owner drops its request or exceeds a hold limit.

Parameters:
- N_REQ, 4, number of requesters (2..4); requester 0 is the memory command port.
- MAX_HOLD, 64, maximum cycles a grant is held before forced revocation; 0 disables the timeout.
- HOLD_W, 7, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_req  input  N_REQ  per-requester ack-bus request (the ack_bus[2] equivalent).
- in_id  input  2*N_REQ  per-requester 2-bit source ID; requester k uses bits [2k+1:2k].
- out_owned  output  N_REQ  one-hot ownership; feeds each requester's owned input.
- out_ack_valid  output  1  one-cycle pulse on the first cycle of a grant.
- out_ack_id  output  2  source ID of the current owner; held for the whole grant.
- out_busy  output  1  high in GRANT and RELEASE.
- out_timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, hold_cnt=0.
  - All outputs 0.
  - Reset mid-grant drops out_owned immediately.
- All outputs are registered.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any in_req bit is set, select the first set bit searching from rr_ptr upward with wrap at N_REQ.
  - Next cycle: state=GRANT, out_owned=onehot(winner), out_ack_id=in_id[winner] latched, out_ack_valid=1, hold_cnt=0.
  - Grant latency is 1 cycle from request sampled high.
- GRANT:
  - out_ack_valid=0 after the first cycle.
  - hold_cnt increments each cycle and saturates.
  - If in_req[owner]=0 -> RELEASE next cycle, out_owned=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> RELEASE next cycle, out_owned=0, out_timeout=1 for that cycle.
  - Request drop has priority over timeout when both occur in the same cycle: no timeout pulse.
  - Requests from other requesters are ignored while in GRANT.
- RELEASE:
  - One idle turnaround cycle with out_owned=0.
  - rr_ptr = (owner+1) mod N_REQ.
  - Next state IDLE; arbitration resumes the following cycle.
  - The revoked owner may win again only if no other request is pending.
- out_ack_id keeps the last owner's ID after release; it is only meaningful while out_busy=1.
- in_id is sampled only in IDLE at grant time; later changes are ignored.
- Requester with a request bit set but N_REQ index out of range: not possible by construction (the vector width is N_REQ).
- Simultaneous requests: only one is granted; losers keep requesting and are served in round-robin order.
- Starvation-free: any held request is granted within N_REQ grants.

Test Plan:
- Reset then single request: assert in_req=4'b0010 with in_id[3:2]=2'b01 -> next cycle out_owned=4'b0010, out_ack_valid=1 for exactly 1 cycle, out_ack_id=2'b01, out_busy=1.
- Release: drop in_req[1] after 5 GRANT cycles -> out_owned=0 the next cycle, one RELEASE cycle, then IDLE; out_timeout stays 0; rr_ptr=2.
- Round-robin: hold in_req=4'b1111, each owner drops its request 3 cycles after grant and reasserts it the following cycle -> grant order 0,1,2,3,0; each grant is separated by one RELEASE cycle.
- Timeout: MAX_HOLD=8, requester 2 holds its request indefinitely -> owned for exactly 8 cycles, then out_owned=0 with out_timeout=1 pulse; with in_req[0] also set, requester 0 is granted next.
- Coincident drop and timeout: drop the request on the cycle hold_cnt==MAX_HOLD-1 -> release happens with out_timeout=0.
- Async reset mid-grant: pull rst_n low in GRANT between clock edges -> out_owned, out_busy and out_ack_valid go to 0 without a clock edge; after release, the first grant goes to the lowest requesting index.
